// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle MIPS-style datapath.
// Sequences FETCH -> DECODE -> EXEC -> MEM -> WB and decodes each state's
// datapath strobes combinationally from state, Opcode, Function_opcode,
// Zero and mem_ready. Optional performance counters are enabled with the
// macro MULTICYCLE_PERF_CNT_EN.
// Ports:
//   clock, reset (async, active-high)
//   Opcode[5:0], Function_opcode[5:0], Zero, mem_ready -- decode inputs
//   state[2:0] -- FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4
//   PCWrite IRWrite MemRead MemWrite RegWrite IorD ALUSrcA Sftmd -- strobes
//   PCSource RegDST MemtoReg ALUSrcB ALUOp [1:0] -- mux selects / ALU op
//   cycle_cnt[31:0], instr_cnt[31:0] -- only with MULTICYCLE_PERF_CNT_EN
module multicycle_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Function_opcode,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic [2:0] state,
`ifdef MULTICYCLE_PERF_CNT_EN
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt,
`endif
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IorD,
    output logic       ALUSrcA,
    output logic       Sftmd,
    output logic [1:0] PCSource,
    output logic [1:0] RegDST,
    output logic [1:0] MemtoReg,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic w_rfmt, w_ifmt, w_lw, w_sw, w_beq, w_bne;
    logic w_j, w_jal, w_jr, w_shift;

    logic       w_pcwrite, w_irwrite, w_memread, w_memwrite;
    logic       w_regwrite, w_iord, w_alusrca, w_sftmd;
    logic [1:0] w_pcsource, w_regdst, w_memtoreg, w_alusrcb, w_aluop;

    assign w_rfmt = (Opcode == 6'b000000);
    assign w_ifmt = (Opcode[5:3] == 3'b001);
    assign w_lw   = (Opcode == 6'b100011);
    assign w_sw   = (Opcode == 6'b101011);
    assign w_beq  = (Opcode == 6'b000100);
    assign w_bne  = (Opcode == 6'b000101);
    assign w_j    = (Opcode == 6'b000010);
    assign w_jal  = (Opcode == 6'b000011);
    assign w_jr   = w_rfmt && (Function_opcode == 6'b001000);

    // sll/srl/sra and their variable-shift forms
    assign w_shift = (Function_opcode == 6'b000000) ||
                     (Function_opcode == 6'b000010) ||
                     (Function_opcode == 6'b000011) ||
                     (Function_opcode == 6'b000100) ||
                     (Function_opcode == 6'b000110) ||
                     (Function_opcode == 6'b000111);

    always_comb begin
        w_next     = S_FETCH;
        w_pcwrite  = 1'b0;
        w_irwrite  = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        w_iord     = 1'b0;
        w_alusrca  = 1'b0;
        w_sftmd    = 1'b0;
        w_pcsource = 2'd0;
        w_regdst   = 2'd0;
        w_memtoreg = 2'd0;
        w_alusrcb  = 2'd0;
        w_aluop    = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_memread = 1'b1;
                w_alusrcb = 2'd1;
                if (mem_ready) begin
                    w_irwrite = 1'b1;
                    w_pcwrite = 1'b1;
                    w_next    = S_DECODE;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_DECODE: begin
                // branch target precomputed while the opcode is decoded
                w_alusrcb = 2'd3;
                if (w_j) begin
                    w_pcwrite  = 1'b1;
                    w_pcsource = 2'd2;
                end else if (w_jal) begin
                    w_pcwrite  = 1'b1;
                    w_pcsource = 2'd2;
                    w_regwrite = 1'b1;
                    w_regdst   = 2'd2;
                    w_memtoreg = 2'd2;
                end else if (w_jr) begin
                    w_pcwrite  = 1'b1;
                    w_pcsource = 2'd3;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_alusrca = 1'b1;
                if (w_rfmt) begin
                    w_aluop = 2'b10;
                    w_sftmd = w_shift;
                    w_next  = S_WB;
                end else if (w_ifmt) begin
                    w_alusrcb = 2'd2;
                    w_aluop   = 2'b10;
                    w_next    = S_WB;
                end else if (w_lw || w_sw) begin
                    w_alusrcb = 2'd2;
                    w_next    = S_MEM;
                end else if (w_beq || w_bne) begin
                    w_aluop    = 2'b01;
                    w_pcsource = 2'd1;
                    w_pcwrite  = w_beq ? Zero : ~Zero;
                end
            end
            S_MEM: begin
                w_iord     = 1'b1;
                w_memread  = w_lw;
                w_memwrite = w_sw;
                if (!mem_ready)
                    w_next = S_MEM;
                else if (w_lw)
                    w_next = S_WB;
            end
            S_WB: begin
                w_regwrite = 1'b1;
                if (w_lw)
                    w_memtoreg = 2'd1;
                else if (w_rfmt)
                    w_regdst = 2'd1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_state <= S_FETCH;
        else
            r_state <= w_next;
    end

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instr_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cycle_cnt <= 32'd0;
            r_instr_cnt <= 32'd0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            // an instruction retires whenever FETCH is re-entered
            if (r_state != S_FETCH && w_next == S_FETCH)
                r_instr_cnt <= r_instr_cnt + 32'd1;
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;
`endif

    assign state = r_state;

    // reset must silence memory/register strobes immediately, even though
    // the state register alone would already sit in FETCH
    assign PCWrite  = w_pcwrite  & ~reset;
    assign IRWrite  = w_irwrite  & ~reset;
    assign MemRead  = w_memread  & ~reset;
    assign MemWrite = w_memwrite & ~reset;
    assign RegWrite = w_regwrite & ~reset;
    assign IorD     = w_iord     & ~reset;
    assign ALUSrcA  = w_alusrca  & ~reset;
    assign Sftmd    = w_sftmd    & ~reset;
    assign PCSource = reset ? 2'd0 : w_pcsource;
    assign RegDST   = reset ? 2'd0 : w_regdst;
    assign MemtoReg = reset ? 2'd0 : w_memtoreg;
    assign ALUSrcB  = reset ? 2'd0 : w_alusrcb;
    assign ALUOp    = reset ? 2'd0 : w_aluop;

endmodule
